// File: rtl/spongent_permute_core.sv
// Iterative Spongent permutation: one round (counter XOR, S-box layer, pLayer) per clock.
// Optional abort input enabled by defining SPONGENT_PERMUTE_ABORT_EN.
module spongent_permute_core #(
   parameter int                WIDTH     = 88,
   parameter int                ROUNDS    = 45,
   parameter int                LFSR_W    = 6,
   parameter logic [LFSR_W-1:0] LFSR_INIT = LFSR_W'(6'h05),
   parameter logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(6'h30)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  state_in,
`ifdef SPONGENT_PERMUTE_ABORT_EN
   input  logic              abort,
`endif
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  state_out,
   output logic [LFSR_W-1:0] lfsr_out
);

   // Handshake: start is taken on an edge where ready=1; done pulses for one
   // cycle when state_out has just been updated with a new result.

   localparam int              CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS + 1) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  state_reg;
   logic [LFSR_W-1:0] lfsr, lfsr_next;
   logic [CNT_W-1:0]  cnt;
   logic              load, step, fin, abort_run;
   logic [WIDTH-1:0]  s_ctr, s_sbox, s_perm;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'hE;
         4'h1: sbox = 4'hD;
         4'h2: sbox = 4'hB;
         4'h3: sbox = 4'h0;
         4'h4: sbox = 4'h2;
         4'h5: sbox = 4'h1;
         4'h6: sbox = 4'h4;
         4'h7: sbox = 4'hF;
         4'h8: sbox = 4'h7;
         4'h9: sbox = 4'hA;
         4'hA: sbox = 4'h8;
         4'hB: sbox = 4'h5;
         4'hC: sbox = 4'h9;
         4'hD: sbox = 4'hC;
         4'hE: sbox = 4'h3;
         default: sbox = 4'h6;
      endcase
   endfunction

   // Round counter enters at the low end and, bit-reversed, at the high end.
   always_comb begin
      s_ctr = state_reg;
      for (int i = 0; i < LFSR_W; i++) begin
         s_ctr[i]           = state_reg[i] ^ lfsr[i];
         s_ctr[WIDTH-1-i]   = state_reg[WIDTH-1-i] ^ lfsr[i];
      end
   end

   always_comb begin
      s_sbox = '0;
      for (int n = 0; n < WIDTH / 4; n++) begin
         s_sbox[4*n +: 4] = sbox(s_ctr[4*n +: 4]);
      end
   end

   always_comb begin
      s_perm = '0;
      for (int j = 0; j < WIDTH - 1; j++) begin
         s_perm[(j * (WIDTH / 4)) % (WIDTH - 1)] = s_sbox[j];
      end
      s_perm[WIDTH-1] = s_sbox[WIDTH-1];
   end

   assign lfsr_next = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      step      = 1'b0;
      fin       = 1'b0;
      abort_run = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef SPONGENT_PERMUTE_ABORT_EN
            if (abort) begin
               abort_run = 1'b1;
               state_d   = IDLE;
            end else begin
`else
            begin
`endif
               step = 1'b1;
               if (cnt == LAST) begin
                  fin     = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= '0;
         state_out <= '0;
         lfsr      <= LFSR_INIT;
         cnt       <= '0;
         done      <= 1'b0;
      end else begin
         done <= fin;
         if (load) begin
            state_reg <= state_in;
            lfsr      <= LFSR_INIT;
            cnt       <= '0;
         end else if (abort_run) begin
            lfsr <= LFSR_INIT;
            cnt  <= '0;
         end else if (step) begin
            state_reg <= s_perm;
            lfsr      <= lfsr_next;
            cnt       <= cnt + CNT_W'(1);
            if (fin) state_out <= s_perm;
         end
      end
   end

   assign ready    = (state_q == IDLE);
   assign busy     = (state_q == RUN);
   assign lfsr_out = lfsr;

endmodule
